// File: rtl/pc_unit_if.sv
// Bundle of the program-counter block's control inputs and fetch/exception outputs.
// master: control unit / register-file side. slave: the pc_unit itself.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    // Control and operand inputs to the PC block
    logic             stall;
    logic [2:0]       pc_src;
    logic             zero;
    logic             neg;
    logic [WIDTH-1:0] rs_data;
    logic [31:0]      instr;
    logic             exc;
    logic             eret;

    // Fetch address and exception state
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             exl;
    logic             taken;
    logic             adel;

    modport master (
        output stall, pc_src, zero, neg, rs_data, instr, exc, eret,
        input  pc, pc_plus4, epc, exl, taken, adel
    );

    modport slave (
        input  stall, pc_src, zero, neg, rs_data, instr, exc, eret,
        output pc, pc_plus4, epc, exl, taken, adel
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the single-cycle MIPS-lite core: owns the PC register and
// selects the next fetch address (sequential, branch, jump, jr), with stall and a
// single-level exception path (EPC, EXL, eret, misaligned jr-target trap).
module pc_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);

    // pc_src encodings
    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BEQ  = 3'b001;
    localparam logic [2:0] PC_BNE  = 3'b010;
    localparam logic [2:0] PC_JMP  = 3'b011;
    localparam logic [2:0] PC_JR   = 3'b100;
    localparam logic [2:0] PC_BLEZ = 3'b101;
    localparam logic [2:0] PC_BGTZ = 3'b110;

    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] PC_INC     = WIDTH'(4);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             exl_q, exl_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] next_pc;
    logic             taken;
    logic             adel;
    logic             trap;

    // Opcode field is decoded upstream; only the immediate/target fields matter here.
    logic unused_instr_hi;
    assign unused_instr_hi = ^bus.instr[31:26];

    // Candidate targets; all sums wrap modulo 2^WIDTH
    always_comb begin
        pc_plus4   = pc_q + PC_INC;
        br_off     = {{(WIDTH-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};
        br_target  = pc_plus4 + br_off;
        jmp_target = {pc_plus4[WIDTH-1:28], bus.instr[25:0], 2'b00};
    end

    // Decode pc_src into a redirect decision and its target
    always_comb begin
        taken           = 1'b0;
        redirect_target = br_target;
        unique case (bus.pc_src)
            PC_SEQ:  taken = 1'b0;
            PC_BEQ:  taken = bus.zero;
            PC_BNE:  taken = ~bus.zero;
            PC_JMP: begin
                taken           = 1'b1;
                redirect_target = jmp_target;
            end
            PC_JR: begin
                // jr still counts as taken when its target traps
                taken           = 1'b1;
                redirect_target = bus.rs_data;
            end
            PC_BLEZ: taken = bus.neg | bus.zero;
            PC_BGTZ: taken = ~bus.neg & ~bus.zero;
            default: taken = 1'b0;
        endcase
        next_pc = taken ? redirect_target : pc_plus4;
    end

    // Misaligned jr target is raised as an address-error exception
    always_comb begin
        adel = (bus.pc_src == PC_JR) && (bus.rs_data[1:0] != 2'b00);
        trap = bus.exc | adel;
    end

    // Next-state priority: trap entry, eret, stall, normal advance
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        exl_d = exl_q;
        if (trap && !exl_q) begin
            epc_d = pc_q;
            exl_d = 1'b1;
            pc_d  = EXC_VEC_W;
        end else if (bus.eret && exl_q) begin
            // Trap requests in the same cycle are dropped, not queued
            pc_d  = epc_q;
            exl_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d  = next_pc;
        end
    end

    // PC, EPC and exception-level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC_W;
            epc_q <= '0;
            exl_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            exl_q <= exl_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.epc      = epc_q;
    assign bus.exl      = exl_q;
    assign bus.taken    = taken;
    assign bus.adel     = adel;

    // Entering the handler must always land on the exception vector
    a_exl_entry_at_vector: assert property (
        @(posedge clk) disable iff (!rst_n) $rose(exl_q) |-> (pc_q == EXC_VEC_W)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios on 32- and 64-bit instances,
// then randomized stimulus against a behavioural next-PC model.
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    pc_unit_if #(.WIDTH(32)) bus32 ();
    pc_unit_if #(.WIDTH(64)) bus64 ();

    pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    pc_unit #(.WIDTH(64), .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic set32(input logic s, input logic [2:0] src, input logic z, input logic n,
                         input logic [31:0] rs, input logic [31:0] ins, input logic e,
                         input logic er);
        bus32.stall = s;  bus32.pc_src = src; bus32.zero = z;  bus32.neg  = n;
        bus32.rs_data = rs; bus32.instr = ins; bus32.exc = e; bus32.eret = er;
    endtask

    task automatic set64(input logic s, input logic [2:0] src, input logic z, input logic n,
                         input logic [63:0] rs, input logic [31:0] ins, input logic e,
                         input logic er);
        bus64.stall = s;  bus64.pc_src = src; bus64.zero = z;  bus64.neg  = n;
        bus64.rs_data = rs; bus64.instr = ins; bus64.exc = e; bus64.eret = er;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves both instances at pc=0x3000, one time unit after a rising edge
    task automatic reset_both();
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0);
        set64(0, 3'b000, 0, 0, 64'h0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_both();
        tick();
        tick();
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 1, 0);
        tick();
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus32.pc !== 32'h0000_3000) begin
            n_fails++; $display("FAIL reset_pc_async: got %h want %h", bus32.pc, 32'h3000);
        end
        n_checks++;
        if (bus32.exl !== 1'b0) begin
            n_fails++; $display("FAIL reset_exl: got %b want 0", bus32.exl);
        end
        n_checks++;
        if (bus32.epc !== 32'h0) begin
            n_fails++; $display("FAIL reset_epc: got %h want 0", bus32.epc);
        end
        n_checks++;
        if (bus64.pc !== 64'h3000) begin
            n_fails++; $display("FAIL reset_pc64: got %h want %h", bus64.pc, 64'h3000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_300C) begin
            n_fails++; $display("FAIL seq_pc: got %h want %h", bus32.pc, 32'h300C);
        end
        n_checks++;
        if (bus32.pc_plus4 !== 32'h0000_3010) begin
            n_fails++; $display("FAIL seq_pc_plus4: got %h want %h", bus32.pc_plus4, 32'h3010);
        end
    endtask

    typedef struct {
        logic [2:0]  src;
        logic        z;
        logic        n;
        logic [15:0] imm;
        logic        tk;
        logic [31:0] pc;
    } br_case_t;

    task automatic test_branches();
        br_case_t cs[10];
        cs[0] = '{3'b001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 32'h0000_3000};  // beq taken
        cs[1] = '{3'b001, 1'b0, 1'b0, 16'hFFFF, 1'b0, 32'h0000_3004};  // beq not taken
        cs[2] = '{3'b010, 1'b1, 1'b0, 16'hFFFF, 1'b0, 32'h0000_3004};  // bne not taken
        cs[3] = '{3'b010, 1'b0, 1'b0, 16'h0010, 1'b1, 32'h0000_3044};  // bne taken
        cs[4] = '{3'b110, 1'b0, 1'b0, 16'h0004, 1'b1, 32'h0000_3014};  // bgtz taken
        cs[5] = '{3'b110, 1'b1, 1'b0, 16'h0004, 1'b0, 32'h0000_3004};  // bgtz zero
        cs[6] = '{3'b101, 1'b0, 1'b1, 16'hFFFF, 1'b1, 32'h0000_3000};  // blez neg
        cs[7] = '{3'b101, 1'b0, 1'b0, 16'hFFFF, 1'b0, 32'h0000_3004};  // blez positive
        cs[8] = '{3'b111, 1'b1, 1'b1, 16'hFFFF, 1'b0, 32'h0000_3004};  // reserved
        cs[9] = '{3'b001, 1'b1, 1'b0, 16'h8000, 1'b1, 32'hFFFE_3004};  // most-negative offset
        foreach (cs[k]) begin
            reset_both();
            set32(0, cs[k].src, cs[k].z, cs[k].n, 32'h0, {16'h0, cs[k].imm}, 0, 0);
            #1;
            n_checks++;
            if (bus32.taken !== cs[k].tk) begin
                n_fails++;
                $display("FAIL branch%0d_taken: got %b want %b", k, bus32.taken, cs[k].tk);
            end
            tick();
            n_checks++;
            if (bus32.pc !== cs[k].pc) begin
                n_fails++;
                $display("FAIL branch%0d_pc: got %h want %h", k, bus32.pc, cs[k].pc);
            end
        end
    endtask

    task automatic test_jumps();
        reset_both();
        set32(0, 3'b011, 0, 0, 32'h0, 32'h0000_0C10, 0, 0);
        #1;
        n_checks++;
        if (bus32.taken !== 1'b1) begin
            n_fails++; $display("FAIL j_taken: got %b want 1", bus32.taken);
        end
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_3040) begin
            n_fails++; $display("FAIL j_pc: got %h want %h", bus32.pc, 32'h3040);
        end
        reset_both();
        set32(0, 3'b100, 0, 0, 32'h0000_3100, 32'h0, 0, 0);
        #1;
        n_checks++;
        if (bus32.adel !== 1'b0) begin
            n_fails++; $display("FAIL jr_adel_aligned: got %b want 0", bus32.adel);
        end
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_3100) begin
            n_fails++; $display("FAIL jr_pc: got %h want %h", bus32.pc, 32'h3100);
        end
        reset_both();
        set32(0, 3'b100, 0, 0, 32'h0000_3102, 32'h0, 0, 0);
        #1;
        n_checks++;
        if (bus32.adel !== 1'b1 || bus32.taken !== 1'b1) begin
            n_fails++;
            $display("FAIL jr_misaligned_flags: got adel=%b taken=%b want 1/1",
                     bus32.adel, bus32.taken);
        end
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_4180 || bus32.epc !== 32'h0000_3000 || bus32.exl !== 1'b1) begin
            n_fails++;
            $display("FAIL jr_misaligned_trap: got pc=%h epc=%h exl=%b want 4180/3000/1",
                     bus32.pc, bus32.epc, bus32.exl);
        end
    endtask

    task automatic test_stall_priority();
        reset_both();
        tick();
        tick();
        set32(1, 3'b011, 0, 0, 32'h0, 32'h0000_0C10, 0, 0);
        #1;
        n_checks++;
        if (bus32.taken !== 1'b1) begin
            n_fails++; $display("FAIL stall_taken: got %b want 1", bus32.taken);
        end
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_3008) begin
            n_fails++; $display("FAIL stall_hold: got %h want %h", bus32.pc, 32'h3008);
        end
        set32(1, 3'b000, 0, 0, 32'h0, 32'h0, 1, 0);
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_4180 || bus32.epc !== 32'h0000_3008 || bus32.exl !== 1'b1) begin
            n_fails++;
            $display("FAIL stall_trap: got pc=%h epc=%h exl=%b want 4180/3008/1",
                     bus32.pc, bus32.epc, bus32.exl);
        end
    endtask

    // Continues from the handler entered by test_stall_priority
    task automatic test_exception_level();
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 1, 0);
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_4184 || bus32.epc !== 32'h0000_3008 || bus32.exl !== 1'b1) begin
            n_fails++;
            $display("FAIL nested_exc: got pc=%h epc=%h exl=%b want 4184/3008/1",
                     bus32.pc, bus32.epc, bus32.exl);
        end
        set32(1, 3'b000, 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_3008 || bus32.epc !== 32'h0000_3008 || bus32.exl !== 1'b0) begin
            n_fails++;
            $display("FAIL eret: got pc=%h epc=%h exl=%b want 3008/3008/0",
                     bus32.pc, bus32.epc, bus32.exl);
        end
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 1);
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0000_300C || bus32.exl !== 1'b0) begin
            n_fails++;
            $display("FAIL eret_ignored: got pc=%h exl=%b want 300c/0", bus32.pc, bus32.exl);
        end
    endtask

    task automatic test_wrap32();
        reset_both();
        set32(0, 3'b100, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0);
        tick();
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0);
        #1;
        n_checks++;
        if (bus32.pc_plus4 !== 32'h0) begin
            n_fails++; $display("FAIL wrap32_plus4: got %h want 0", bus32.pc_plus4);
        end
        tick();
        n_checks++;
        if (bus32.pc !== 32'h0) begin
            n_fails++; $display("FAIL wrap32_pc: got %h want 0", bus32.pc);
        end
    endtask

    task automatic test_wide64();
        reset_both();
        set64(0, 3'b100, 0, 0, 64'h1234_5678_9ABC_DEF0, 32'h0, 0, 0);
        tick();
        set64(0, 3'b011, 0, 0, 64'h0, 32'h0000_0C10, 0, 0);
        tick();
        n_checks++;
        if (bus64.pc !== 64'h1234_5678_9000_3040) begin
            n_fails++;
            $display("FAIL j64_upper: got %h want %h", bus64.pc, 64'h1234_5678_9000_3040);
        end
        set64(0, 3'b100, 0, 0, 64'h0000_0000_FFFF_FFFC, 32'h0, 0, 0);
        tick();
        set64(0, 3'b001, 1, 0, 64'h0, 32'h0000_0001, 0, 0);
        tick();
        n_checks++;
        if (bus64.pc !== 64'h0000_0001_0000_0004) begin
            n_fails++;
            $display("FAIL br64_carry: got %h want %h", bus64.pc, 64'h0000_0001_0000_0004);
        end
        set64(0, 3'b100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 0, 0);
        tick();
        set64(0, 3'b000, 0, 0, 64'h0, 32'h0, 0, 0);
        tick();
        n_checks++;
        if (bus64.pc !== 64'h0) begin
            n_fails++; $display("FAIL wrap64_pc: got %h want 0", bus64.pc);
        end
    endtask

    // Behavioural model: next PC from plain arithmetic on the architectural state
    task automatic test_random(input int w, input int n_cyc);
        logic [63:0] m_pc, m_epc, msk, p4, bt, jt, tgt, nxt, rs;
        logic [63:0] a_pc, a_p4, a_epc;
        logic        m_exl, tk, adl, trap, s, z, ng, e, er, a_tk, a_adel, a_exl;
        logic [2:0]  src;
        logic [31:0] ins;
        longint      off;
        msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        reset_both();
        m_pc  = 64'h3000;
        m_epc = 64'h0;
        m_exl = 1'b0;
        for (int i = 0; i < n_cyc; i++) begin
            s   = ($urandom_range(0, 4) == 0);
            src = 3'($urandom_range(0, 7));
            z   = 1'($urandom_range(0, 1));
            ng  = 1'($urandom_range(0, 1));
            rs  = {$urandom, $urandom} & msk;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            ins = $urandom;
            e   = ($urandom_range(0, 9) == 0);
            er  = ($urandom_range(0, 5) == 0);
            if (w == 32) set32(s, src, z, ng, rs[31:0], ins, e, er);
            else         set64(s, src, z, ng, rs, ins, e, er);

            p4  = (m_pc + 64'd4) & msk;
            off = longint'(signed'(ins[15:0]));
            bt  = (p4 + 64'(off * 4)) & msk;
            jt  = (p4 - (p4 % 64'h1000_0000) + 64'(ins[25:0]) * 64'd4) & msk;
            tgt = bt;
            case (src)
                3'd1: tk = z;
                3'd2: tk = !z;
                3'd3: begin tk = 1'b1; tgt = jt; end
                3'd4: begin tk = 1'b1; tgt = rs; end
                3'd5: tk = ng || z;
                3'd6: tk = !ng && !z;
                default: tk = 1'b0;
            endcase
            nxt  = tk ? tgt : p4;
            adl  = (src == 3'd4) && (rs % 4 != 0);
            trap = e || adl;

            #1;
            a_tk   = (w == 32) ? bus32.taken : bus64.taken;
            a_adel = (w == 32) ? bus32.adel  : bus64.adel;
            a_p4   = (w == 32) ? {32'h0, bus32.pc_plus4} : bus64.pc_plus4;
            n_checks++;
            if (a_tk !== tk) begin
                n_fails++; $display("FAIL rand%0d_taken cyc %0d: got %b want %b", w, i, a_tk, tk);
            end
            n_checks++;
            if (a_adel !== adl) begin
                n_fails++; $display("FAIL rand%0d_adel cyc %0d: got %b want %b", w, i, a_adel, adl);
            end
            n_checks++;
            if (a_p4 !== p4) begin
                n_fails++; $display("FAIL rand%0d_plus4 cyc %0d: got %h want %h", w, i, a_p4, p4);
            end

            if (trap && !m_exl) begin
                m_epc = m_pc;
                m_exl = 1'b1;
                m_pc  = 64'h4180;
            end else if (er && m_exl) begin
                m_pc  = m_epc;
                m_exl = 1'b0;
            end else if (!s) begin
                m_pc  = nxt;
            end

            tick();
            a_pc  = (w == 32) ? {32'h0, bus32.pc}  : bus64.pc;
            a_epc = (w == 32) ? {32'h0, bus32.epc} : bus64.epc;
            a_exl = (w == 32) ? bus32.exl : bus64.exl;
            n_checks++;
            if (a_pc !== m_pc) begin
                n_fails++; $display("FAIL rand%0d_pc cyc %0d: got %h want %h", w, i, a_pc, m_pc);
            end
            n_checks++;
            if (a_epc !== m_epc) begin
                n_fails++; $display("FAIL rand%0d_epc cyc %0d: got %h want %h", w, i, a_epc, m_epc);
            end
            n_checks++;
            if (a_exl !== m_exl) begin
                n_fails++; $display("FAIL rand%0d_exl cyc %0d: got %b want %b", w, i, a_exl, m_exl);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        set32(0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0);
        set64(0, 3'b000, 0, 0, 64'h0, 32'h0, 0, 0);
        #1;
        rst_n = 1'b0;
        test_reset();
        test_branches();
        test_jumps();
        test_stall_priority();
        test_exception_level();
        test_wrap32();
        test_wide64();
        test_random(32, 400);
        test_random(64, 400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
